// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/redirect sequencing for the five-stage pipeline,
// driven by a three-entry scoreboard of in-flight register writes.
module pipe_hazard_ctrl #(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [2:0]  id_rs,
    input  logic [2:0]  id_rt,
    input  logic        id_wr_en,
    input  logic [2:0]  id_wr_reg,
    input  logic        id_halt,
    input  logic        ex_redirect,
    input  logic [15:0] ex_target,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        pc_redirect,
    output logic [15:0] redirect_pc,
    output logic        if_id_we,
    output logic        id_ex_we,
    output logic        ex_mem_we,
    output logic        mem_wb_we,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        stall_id,
    output logic        halted
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [2:0]      sb_v_q, sb_v_d;
    logic [2:0][2:0] sb_r_q, sb_r_d;
    logic            hit_rs, hit_rt, hazard, advance, issue;

    // Index 0 is EX, 1 is MEM, 2 is WB; WB is skipped when the regfile bypasses.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb_v_q[i] && (i < 2 || !WB_BYPASS)) begin
                hit_rs = hit_rs | (sb_r_q[i] == id_rs);
                hit_rt = hit_rt | (sb_r_q[i] == id_rt);
            end
        end
    end

    assign hazard      = id_valid && ((id_rs_used && hit_rs) || (id_rt_used && hit_rt));
    assign advance     = !mem_busy && state_q != HALTED;
    assign issue       = advance && id_valid && !hazard && !ex_redirect && state_q == RUN;
    assign redirect_pc = ex_target;
    assign halted      = state_q == HALTED;

    always_comb begin
        {pc_we, pc_redirect, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '0;
        {if_id_flush, id_ex_bubble, stall_id} = '0;
        if (rst && !mem_busy) begin
            if (state_q == DRAIN)
                {if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush, id_ex_bubble} = '1;
            else if (state_q == RUN) begin
                if (ex_redirect)
                    {pc_we, pc_redirect, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                     if_id_flush, id_ex_bubble} = '1;
                else if (hazard)
                    {id_ex_we, ex_mem_we, mem_wb_we, id_ex_bubble, stall_id} = '1;
                else
                    {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we} = '1;
            end
        end
    end

    // HALT enters EX without a register write; the drain counter tracks it to WB.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sb_v_d  = sb_v_q;
        sb_r_d  = sb_r_q;
        if (advance) begin
            sb_v_d = {sb_v_q[1:0], issue && id_wr_en && !id_halt};
            sb_r_d = {sb_r_q[1:0], id_wr_reg};
            if (issue && id_halt) begin
                state_d = DRAIN;
                cnt_d   = 2'd0;
            end else if (state_q == DRAIN) begin
                cnt_d   = cnt_q + 2'd1;
                state_d = cnt_q == 2'd2 ? HALTED : DRAIN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            sb_v_q  <= '0;
            sb_r_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sb_v_q  <= sb_v_d;
            sb_r_q  <= sb_r_d;
        end
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage WISC pipeline. It owns the write enables and flush/bubble controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It tracks in-flight register writes in a three-entry scoreboard, stalls decode on RAW hazards (the datapath has no forwarding), and redirects fetch when the execute stage resolves a taken branch or jump. It also freezes the pipe on data-memory stalls and drains the pipe on HALT.

## Interface
Parameters:
- WB_BYPASS, default 1: 1 = register file bypasses same-cycle write to read, so the WB entry is excluded from hazard checks; 0 = WB entry is checked.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt
- id_rs, id_rt  in  3 each  ID source register numbers
- id_wr_en  in  1  ID instruction writes the register file
- id_wr_reg  in  3  ID destination register
- id_halt  in  1  ID instruction is HALT
- ex_redirect  in  1  execute resolved a taken branch/jump (brOrJmp or aluJump)
- ex_target  in  16  execute next_pc
- mem_busy  in  1  data memory not ready this cycle
- pc_we  out  1  PC register write enable
- pc_redirect  out  1  select redirect_pc as next PC
- redirect_pc  out  16  equals ex_target
- if_id_we, id_ex_we, ex_mem_we, mem_wb_we  out  1 each  pipeline register enables
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- stall_id  out  1  decode RAW stall active (debug)
- halted  out  1  pipe fully drained after HALT

## Operation
- Scoreboard: entries sb[0] (EX), sb[1] (MEM), sb[2] (WB), each {v, reg[2:0]}. All entries are cleared on reset.
- An **advance** cycle is any cycle with !mem_busy and state != HALTED. On advance, the entries shift: sb[2]<=sb[1] and sb[1]<=sb[0].
  - sb[0] <= {1, id_wr_reg} if the ID instruction issues and id_wr_en; otherwise sb[0] <= {0, x}.
- hazard = id_valid & ((id_rs_used & hit(id_rs)) | (id_rt_used & hit(id_rt))).
  - hit(r) is true when r matches any valid sb[0] or sb[1] entry, and also sb[2] when WB_BYPASS=0.
  - R0 is an ordinary register with no special case.
- Issue = advance & id_valid & !hazard & !ex_redirect & state==RUN.
- Priority per cycle (highest first):
  - **Freeze (mem_busy):** every *_we = 0; flush, bubble, pc_redirect = 0. The scoreboard and state hold. A pending ex_redirect stays asserted because EX is frozen, and is acted on in the first non-busy cycle.
  - **Redirect (ex_redirect, RUN):**
    - pc_we=1, pc_redirect=1, if_id_flush=1, id_ex_bubble=1, all other *_we=1.
    - This overrides any hazard and any id_halt; the squashed HALT does not enter DRAIN.
  - **Hazard (RUN):**
    - pc_we=0, if_id_we=0, stall_id=1.
    - id_ex_bubble=1, id_ex_we=1, ex_mem_we=1, mem_wb_we=1.
  - **Normal (RUN):** all *_we=1; flush and bubble = 0.
- State machine:
  - **RUN → DRAIN** when HALT issues (id_halt & issue). The HALT itself advances into EX carrying no register write.
  - **DRAIN:**
    - pc_we=0, if_id_flush=1, id_ex_bubble=1; downstream enables = 1.
    - A 2-bit counter loads 0 on entry and increments on each advance.
    - When the counter is 2 and the cycle advances, the next state is HALTED; HALT has then passed WB.
    - mem_busy pauses the counter.
  - **HALTED:** all *_we=0, halted=1. Exit only via reset.
- redirect_pc = ex_target at all times. pc_redirect qualifies it.

## Timing
- Control outputs are combinational from current state, scoreboard and inputs, and are valid in the same cycle. State and scoreboard update at posedge clk.
- RAW stall length depends on where the writer is:
  - Writer in EX: 2 stall cycles with WB_BYPASS=1, 3 with WB_BYPASS=0.
  - Writer in MEM: 1 / 2 cycles.
  - Each mem_busy cycle adds one cycle.
- Redirect penalty: 2 squashed instructions (IF, ID). The new PC is fetched the cycle after ex_redirect.
- HALT: halted asserts 3 advance cycles after the cycle HALT issues.
- While rst is low: state=RUN, scoreboard empty, all *_we=0, flush, bubble, pc_redirect, stall_id and halted = 0.
- Reset deassertion mid-drain or mid-stall returns the block to RUN with an empty scoreboard. The enclosing design is responsible for resetting the pipe.

## Test plan
- **Back-to-back RAW:** write r3 then read r3, WB_BYPASS=1.
  - stall_id=1 for exactly 2 cycles; pc_we=0 and id_ex_bubble=1 during both.
  - The reader issues in the 3rd cycle.
  - With WB_BYPASS=0 the stall is 3 cycles.
- **Taken branch while ID holds a dependent reader:**
  - ex_redirect=1, ex_target=0x0040 → same cycle pc_redirect=1, redirect_pc=0x0040, if_id_flush=1, id_ex_bubble=1, stall_id ignored.
  - Next cycle sb[0].v=0.
- **mem_busy held 4 cycles with ex_redirect=1:**
  - All enables 0 and pc_redirect=0 for 4 cycles.
  - In the 5th cycle pc_redirect=1 and pc_we=1.
- **HALT in ID, no hazards:** RUN→DRAIN; halted=1 after 3 advance cycles. If mem_busy is inserted once during DRAIN, halted=1 after 4 cycles.
- **HALT in ID with ex_redirect=1:** no DRAIN entry; halted stays 0; the pipe refetches at ex_target.
- **Async reset asserted mid-DRAIN:** all outputs immediately 0. After release: state RUN, pc_we=1, scoreboard empty (a read of any register issues without stall).
